hazard_ctrl_unit: RTL and testbench

- Next-generation hazard unit for the 5-stage pipelined RISC-V core.
- Keeps the existing M/W-to-E operand forwarding.
- Adds load-use stall, branch-taken flush, and a multi-cycle execute (mul/div) hold.
- Adds a saturating stall-cycle counter.
- Sits beside the pipeline registers and drives their stall/flush enables and the E-stage forwarding muxes.

---
 rtl/hazard_pkg.sv | 41 ++++
 rtl/hazard_ctrl_unit_if.sv | 59 +++++
 rtl/mc_hold_ctr.sv | 48 ++++
 rtl/hazard_ctrl_unit.sv | 92 +++++++++
 tb/tb_hazard_ctrl_unit.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package hazard_pkg;

  // Register index width for the 32-entry architectural register file.
  localparam int REG_ADDR_W_DEF = 5;

  typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_t;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  localparam reg_addr_t REG_X0 = '0;

  // Select encoding for the E-stage operand muxes.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Operand source for one E-stage source register.
  // M is checked last so that it overrides W: M holds the younger result.
  function automatic fwd_sel_t fwd_select(
    input logic      rw_m,
    input reg_addr_t rd_m,
    input logic      rw_w,
    input reg_addr_t rd_w,
    input reg_addr_t rs
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (rw_w && (rd_w != REG_X0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    if (rw_m && (rd_m != REG_X0) && (rd_m == rs)) begin
      sel = FWD_M;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle between the pipeline datapath and the hazard unit.
// Latency: n/a (wires only).
// Backpressure: the stall/flush signals carried here are the backpressure.
interface hazard_ctrl_unit_if
  import hazard_pkg::*;
#(
  parameter int PERF_W = 32
);

  // Register indices and control bits observed from the pipeline.
  reg_addr_t Rs1_D;
  reg_addr_t Rs2_D;
  reg_addr_t Rs1_E;
  reg_addr_t Rs2_E;
  reg_addr_t RD_E;
  logic      RegWriteE;
  logic      LoadE;
  logic      McOpE;
  logic      PCSrcE;
  reg_addr_t RD_M;
  reg_addr_t RD_W;
  logic      RegWriteM;
  logic      RegWriteW;

  // Controls returned to the pipeline registers and E-stage muxes.
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              McBusy;
  logic [PERF_W-1:0] StallCount;

  // Pipeline side: reports stage state, obeys stall/flush/forward controls.
  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E,
    output RegWriteE, LoadE, McOpE, PCSrcE,
    output RD_M, RD_W, RegWriteM, RegWriteW,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  McBusy, StallCount
  );

  // Hazard unit side.
  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E,
    input  RegWriteE, LoadE, McOpE, PCSrcE,
    input  RD_M, RD_W, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output McBusy, StallCount
  );

endinterface

// File: rtl/mc_hold_ctr.sv
// Holds a multi-cycle (mul/div) op in E until it has spent MC_LAT cycles there.
// Latency: mc_stall is combinational from mc_op/pc_src and the cycle counter.
// Backpressure: mc_stall is the hold request; it never waits on anything.
module mc_hold_ctr #(
  parameter int MC_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic mc_op,
  input  logic pc_src,
  output logic mc_stall
);

  // A 1-bit counter still exists for MC_LAT = 1; it simply never leaves 0.
  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_LAT - 1);

  // Cycles the current op has already spent in E.
  logic [CNT_W-1:0] mc_cnt;
  logic [CNT_W-1:0] mc_cnt_nxt;

  // Hold while the op has not yet reached its final E cycle; masked in reset.
  always_comb begin
    mc_stall = 1'b0;
    if (!rst && mc_op && !pc_src && (mc_cnt != CNT_LAST)) begin
      mc_stall = 1'b1;
    end
  end

  // Count up while holding; any non-holding cycle (op finished, op gone,
  // or a redirect) starts the next op from zero.
  always_comb begin
    mc_cnt_nxt = '0;
    if (mc_stall) begin
      mc_cnt_nxt = mc_cnt + 1'b1;
    end
  end

  // Counter register; reset abandons any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_cnt <= '0;
    end else begin
      mc_cnt <= mc_cnt_nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard unit for the 5-stage core: forwarding, load-use, branch flush, mul/div hold.
// Latency: all controls combinational in the same cycle; StallCount updates at the edge.
// Backpressure: issues stalls/flushes to the pipeline; never stalled itself.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 3,
  parameter int PERF_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_unit_if.slave hif
);

  logic mc_stall;
  logic ld_hit;
  logic lw_stall;
  logic br_take;

  logic [PERF_W-1:0] stall_count;

  mc_hold_ctr #(
    .MC_LAT (MC_LAT)
  ) u_mc_hold (
    .clk      (clk),
    .rst      (rst),
    .mc_op    (hif.McOpE),
    .pc_src   (hif.PCSrcE),
    .mc_stall (mc_stall)
  );

  // Hazard classification. A multi-cycle hold outranks a redirect (a held
  // op never resolves a branch), and a redirect makes a load-use bubble moot
  // because the dependent instruction in D is being squashed anyway.
  always_comb begin
    ld_hit = hif.LoadE && hif.RegWriteE && (hif.RD_E != REG_X0) &&
             ((hif.RD_E == hif.Rs1_D) || (hif.RD_E == hif.Rs2_D));
    br_take  = !rst && hif.PCSrcE && !mc_stall;
    lw_stall = !rst && ld_hit && !hif.PCSrcE && !mc_stall;
  end

  // Drive forwarding selects and pipeline-register enables; all zero in reset.
  // lw_stall and br_take both exclude mc_stall, so FlushE and StallE are
  // mutually exclusive by construction.
  always_comb begin
    hif.ForwardAE = FWD_RF;
    hif.ForwardBE = FWD_RF;
    hif.StallF    = 1'b0;
    hif.StallD    = 1'b0;
    hif.StallE    = 1'b0;
    hif.FlushD    = 1'b0;
    hif.FlushE    = 1'b0;
    hif.FlushM    = 1'b0;
    hif.McBusy    = 1'b0;
    if (!rst) begin
      hif.ForwardAE = fwd_select(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.Rs1_E);
      hif.ForwardBE = fwd_select(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.Rs2_E);
      // A held op freezes F/D/E and inserts bubbles into M behind it.
      hif.StallF    = mc_stall || lw_stall;
      hif.StallD    = mc_stall || lw_stall;
      hif.StallE    = mc_stall;
      hif.FlushM    = mc_stall;
      hif.McBusy    = mc_stall;
      // Redirect squashes the two wrong-path instructions; load-use inserts
      // one bubble into E while F/D wait for the load data.
      hif.FlushD    = br_take;
      hif.FlushE    = br_take || lw_stall;
    end
  end

  // Saturating count of fetch-stall cycles for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (hif.StallF && (stall_count != {PERF_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign hif.StallCount = stall_count;

  // A stage cannot both hold its contents and be cleared in the same cycle.
  a_no_flush_e_while_stall_e : assert property (
    @(posedge clk) disable iff (rst) !(hif.FlushE && hif.StallE)
  );

  // A hold on E always implies the upstream stages hold as well.
  a_stall_e_implies_upstream : assert property (
    @(posedge clk) disable iff (rst) hif.StallE |-> (hif.StallF && hif.StallD)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  localparam int MC_LAT = 3;
  localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
  localparam longint unsigned MAX3  = 64'd7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.PERF_W(32)) hif();
  hazard_ctrl_unit_if #(.PERF_W(3))  hif_s();
  hazard_ctrl_unit_if #(.PERF_W(32)) hif_1();

  hazard_ctrl_unit #(.MC_LAT(MC_LAT), .PERF_W(32)) dut    (.clk(clk), .rst(rst), .hif(hif));
  hazard_ctrl_unit #(.MC_LAT(MC_LAT), .PERF_W(3))  u_sat  (.clk(clk), .rst(rst), .hif(hif_s));
  hazard_ctrl_unit #(.MC_LAT(1),      .PERF_W(32)) u_lat1 (.clk(clk), .rst(rst), .hif(hif_1));

  // The secondary instances see exactly the same pipeline state.
  assign hif_s.Rs1_D = hif.Rs1_D;         assign hif_1.Rs1_D = hif.Rs1_D;
  assign hif_s.Rs2_D = hif.Rs2_D;         assign hif_1.Rs2_D = hif.Rs2_D;
  assign hif_s.Rs1_E = hif.Rs1_E;         assign hif_1.Rs1_E = hif.Rs1_E;
  assign hif_s.Rs2_E = hif.Rs2_E;         assign hif_1.Rs2_E = hif.Rs2_E;
  assign hif_s.RD_E = hif.RD_E;           assign hif_1.RD_E = hif.RD_E;
  assign hif_s.RegWriteE = hif.RegWriteE; assign hif_1.RegWriteE = hif.RegWriteE;
  assign hif_s.LoadE = hif.LoadE;         assign hif_1.LoadE = hif.LoadE;
  assign hif_s.McOpE = hif.McOpE;         assign hif_1.McOpE = hif.McOpE;
  assign hif_s.PCSrcE = hif.PCSrcE;       assign hif_1.PCSrcE = hif.PCSrcE;
  assign hif_s.RD_M = hif.RD_M;           assign hif_1.RD_M = hif.RD_M;
  assign hif_s.RD_W = hif.RD_W;           assign hif_1.RD_W = hif.RD_W;
  assign hif_s.RegWriteM = hif.RegWriteM; assign hif_1.RegWriteM = hif.RegWriteM;
  assign hif_s.RegWriteW = hif.RegWriteW; assign hif_1.RegWriteW = hif.RegWriteW;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // age: cycles the current multi-cycle op has spent in E so far.
  int age = 0;
  longint unsigned cnt_main = 0;
  longint unsigned cnt_sat  = 0;

  function automatic logic m_hold();
    return !rst && hif.McOpE && !hif.PCSrcE && (age < MC_LAT - 1);
  endfunction

  function automatic logic m_lw();
    logic dep;
    dep = hif.LoadE && hif.RegWriteE && (hif.RD_E != 0) &&
          ((hif.RD_E == hif.Rs1_D) || (hif.RD_E == hif.Rs2_D));
    return !rst && dep && !hif.PCSrcE && !m_hold();
  endfunction

  function automatic logic m_br();
    return !rst && hif.PCSrcE && !m_hold();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rst) return 2'b00;
    if (hif.RegWriteM && hif.RD_M != 0 && hif.RD_M == rs) return 2'b10;
    if (hif.RegWriteW && hif.RD_W != 0 && hif.RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      age = 0;
      cnt_main = 0;
      cnt_sat = 0;
    end else begin
      if (m_hold() || m_lw()) begin
        if (cnt_main < MAX32) cnt_main++;
        if (cnt_sat < MAX3) cnt_sat++;
      end
      age = m_hold() ? age + 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("fwd_a",     64'(hif.ForwardAE),  64'(m_fwd(hif.Rs1_E)));
    chk("fwd_b",     64'(hif.ForwardBE),  64'(m_fwd(hif.Rs2_E)));
    chk("stall_f",   64'(hif.StallF),     64'(m_hold() || m_lw()));
    chk("stall_d",   64'(hif.StallD),     64'(m_hold() || m_lw()));
    chk("stall_e",   64'(hif.StallE),     64'(m_hold()));
    chk("flush_d",   64'(hif.FlushD),     64'(m_br()));
    chk("flush_e",   64'(hif.FlushE),     64'(m_br() || m_lw()));
    chk("flush_m",   64'(hif.FlushM),     64'(m_hold()));
    chk("mc_busy",   64'(hif.McBusy),     64'(m_hold()));
    chk("stall_cnt", 64'(hif.StallCount), cnt_main);
    chk("sat_cnt",   64'(hif_s.StallCount), cnt_sat);
    chk("lat1_busy", 64'(hif_1.McBusy),   64'(0));
    chk("lat1_stall_e", 64'(hif_1.StallE), 64'(0));
  end

  // ---------------- directed stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs1_D = '0; hif.Rs2_D = '0; hif.Rs1_E = '0; hif.Rs2_E = '0;
    hif.RD_E = '0; hif.RegWriteE = 1'b0; hif.LoadE = 1'b0;
    hif.McOpE = 1'b0; hif.PCSrcE = 1'b0;
    hif.RD_M = '0; hif.RD_W = '0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
  endtask

  initial begin
    clear_inputs();
    #1;
    // Reset masks a live M-forward.
    rst = 1'b1;
    hif.RegWriteM = 1'b1; hif.RD_M = 5'd5; hif.Rs1_E = 5'd5;
    sample();
    chk("rst_fwd_a", 64'(hif.ForwardAE), 64'(2'b00));
    chk("rst_stall_f", 64'(hif.StallF), 64'(0));
    chk("rst_cnt", 64'(hif.StallCount), 64'(0));

    next_cycle(); rst = 1'b0;
    sample();
    chk("rel_fwd_a", 64'(hif.ForwardAE), 64'(2'b10));
    chk("rel_mc_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(0));

    // M beats W; then W alone; then x0 never forwards.
    next_cycle();
    hif.RegWriteM = 1'b1; hif.RD_M = 5'd6; hif.RegWriteW = 1'b1; hif.RD_W = 5'd6;
    hif.Rs1_E = 5'd6; hif.Rs2_E = 5'd6;
    sample();
    chk("mw_fwd_a", 64'(hif.ForwardAE), 64'(2'b10));
    chk("mw_fwd_b", 64'(hif.ForwardBE), 64'(2'b10));
    next_cycle(); hif.RD_M = 5'd7;
    sample();
    chk("w_fwd_a", 64'(hif.ForwardAE), 64'(2'b01));
    chk("w_fwd_b", 64'(hif.ForwardBE), 64'(2'b01));
    next_cycle(); hif.RD_M = 5'd0; hif.RD_W = 5'd0; hif.Rs1_E = 5'd0; hif.Rs2_E = 5'd0;
    sample();
    chk("x0_fwd_a", 64'(hif.ForwardAE), 64'(2'b00));

    // Load-use on rs2: one bubble.
    next_cycle(); clear_inputs();
    hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RD_E = 5'd3; hif.Rs2_D = 5'd3;
    sample();
    chk("lu_stall_f", 64'(hif.StallF), 64'(1));
    chk("lu_stall_d", 64'(hif.StallD), 64'(1));
    chk("lu_flush_e", 64'(hif.FlushE), 64'(1));
    chk("lu_stall_e", 64'(hif.StallE), 64'(0));
    next_cycle(); clear_inputs();
    sample();
    chk("lu_cnt", 64'(hif.StallCount), 64'(1));
    chk("lu_done", 64'(hif.StallF), 64'(0));

    // Load into x0 is not a dependency.
    next_cycle();
    hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RD_E = 5'd0; hif.Rs2_D = 5'd0;
    sample();
    chk("lu_x0_stall", 64'(hif.StallF), 64'(0));

    // Redirect wins over load-use.
    next_cycle(); clear_inputs();
    hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RD_E = 5'd3; hif.Rs2_D = 5'd3;
    hif.PCSrcE = 1'b1;
    sample();
    chk("br_flush_d", 64'(hif.FlushD), 64'(1));
    chk("br_flush_e", 64'(hif.FlushE), 64'(1));
    chk("br_stall_f", 64'(hif.StallF), 64'(0));
    chk("br_stall_d", 64'(hif.StallD), 64'(0));

    // Multi-cycle op: 2 hold cycles, released on the 3rd.
    next_cycle(); clear_inputs(); hif.McOpE = 1'b1;
    sample();
    chk("mc1_busy", 64'(hif.McBusy), 64'(1));
    chk("mc1_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(0));
    chk("mc1_lat1", 64'(hif_1.McBusy), 64'(0));
    next_cycle();
    sample();
    chk("mc2_busy", 64'(hif.McBusy), 64'(1));
    chk("mc2_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(1));
    next_cycle();
    sample();
    chk("mc3_busy", 64'(hif.McBusy), 64'(0));
    chk("mc3_stall_f", 64'(hif.StallF), 64'(0));
    chk("mc3_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(2));
    next_cycle(); hif.McOpE = 1'b0;
    sample();
    chk("mc_end_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(0));
    chk("mc_stallcnt", 64'(hif.StallCount), 64'(3));

    // Reset in the middle of a hold abandons it.
    next_cycle(); hif.McOpE = 1'b1;
    sample();
    chk("mr1_busy", 64'(hif.McBusy), 64'(1));
    next_cycle(); rst = 1'b1;
    sample();
    chk("mr_rst_busy", 64'(hif.McBusy), 64'(0));
    chk("mr_rst_stall", 64'(hif.StallF), 64'(0));
    chk("mr_rst_cnt", 64'(hif.StallCount), 64'(0));
    next_cycle(); rst = 1'b0;
    sample();
    chk("mr2_cnt", 64'(dut.u_mc_hold.mc_cnt), 64'(0));
    chk("mr2_busy", 64'(hif.McBusy), 64'(1));
    next_cycle();
    sample();
    chk("mr3_busy", 64'(hif.McBusy), 64'(1));
    next_cycle();
    sample();
    chk("mr4_busy", 64'(hif.McBusy), 64'(0));
    next_cycle(); hif.McOpE = 1'b0;
    sample();
    chk("mr_stallcnt", 64'(hif.StallCount), 64'(2));

    // Seven continuous load-use stall cycles: 3-bit counter pins at 7.
    next_cycle();
    hif.LoadE = 1'b1; hif.RegWriteE = 1'b1; hif.RD_E = 5'd9; hif.Rs1_D = 5'd9;
    repeat (6) next_cycle();
    next_cycle(); clear_inputs();
    sample();
    chk("sat_main", 64'(hif.StallCount), 64'(9));
    chk("sat_small", 64'(hif_s.StallCount), 64'(7));
    next_cycle();
    sample();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
